// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared types and widths for the data memory arbiter.
// Rev 1.0
`default_nettype none

package data_mem_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  typedef logic port_idx_t;

endpackage

`default_nettype wire

// File: rtl/data_mem_arb_pick.sv
// data_mem_arb_pick: combinational one-hot winner selection; DATA_MEM_ARB_RR_EN enables round-robin.
// Rev 1.0
`default_nettype none

module data_mem_arb_pick
  import data_mem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  owner_e     owner,
  input  port_idx_t  last_grant,
  output logic [1:0] gnt
);

`ifndef DATA_MEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    gnt = 2'b00;
    case (owner)
      // The owning port always wins; the other port may use an idle owner cycle.
      OWN0: begin
        if (req0)      gnt = 2'b01;
        else if (req1) gnt = 2'b10;
      end
      OWN1: begin
        if (req1)      gnt = 2'b10;
        else if (req0) gnt = 2'b01;
      end
      default: begin
        if (req0 && req1) begin
`ifdef DATA_MEM_ARB_RR_EN
          gnt = last_grant ? 2'b01 : 2'b10;
`else
          gnt = 2'b01;
`endif
        end else if (req0) begin
          gnt = 2'b01;
        end else if (req1) begin
          gnt = 2'b10;
        end
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter with bus locking in front of a 256x8 data memory.
// Rev 1.0 -- DATA_MEM_ARB_RR_EN selects round-robin instead of fixed port-0 priority.
`default_nettype none

module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int LOCK_MAX = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic              Lock0,
  input  logic              Lock1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] Wdata0,
  input  logic [DATA_W-1:0] Wdata1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              Rvalid0,
  output logic              Rvalid1,
  output logic [DATA_W-1:0] Rdata0,
  output logic [DATA_W-1:0] Rdata1,
  output logic [ADDR_W-1:0] DataAddress,
  output logic              ReadMem,
  output logic              WriteMem,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut,
  output logic [1:0]        Owner
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  owner_e           owner;
  logic [CNT_W-1:0] lock_cnt;
  port_idx_t        last_grant;
  logic [1:0]       pick_gnt;
  logic [1:0]       gnt;
  logic             rvalid0_q;
  logic             rvalid1_q;
  logic             rd0;
  logic             rd1;
  int               cnt_next;
  logic             lock_hit;

  data_mem_arb_pick u_pick (
    .req0       (Req0),
    .req1       (Req1),
    .owner      (owner),
    .last_grant (last_grant),
    .gnt        (pick_gnt)
  );

  assign gnt      = Reset ? 2'b00 : pick_gnt;
  assign Gnt0     = gnt[0];
  assign Gnt1     = gnt[1];
  assign rd0      = gnt[0] & ~We0;
  assign rd1      = gnt[1] & ~We1;
  assign Owner    = owner;
  assign cnt_next = int'(lock_cnt) + 1;
  assign lock_hit = cnt_next >= LOCK_MAX;

  always_comb begin
    DataAddress = '0;
    DataIn      = '0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    if (gnt[0]) begin
      DataAddress = Addr0;
      DataIn      = Wdata0;
      ReadMem     = ~We0;
      WriteMem    = We0;
    end else if (gnt[1]) begin
      DataAddress = Addr1;
      DataIn      = Wdata1;
      ReadMem     = ~We1;
      WriteMem    = We1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      owner      <= IDLE;
      lock_cnt   <= '0;
      last_grant <= 1'b1;
    end else begin
      if (|gnt) last_grant <= gnt[1];
      case (owner)
        IDLE: begin
          lock_cnt <= '0;
          if (gnt[0] && Lock0)      owner <= OWN0;
          else if (gnt[1] && Lock1) owner <= OWN1;
        end
        OWN0: begin
          if (gnt[0] && Lock0 && !lock_hit) begin
            lock_cnt <= CNT_W'(cnt_next);
          end else begin
            owner    <= IDLE;
            lock_cnt <= '0;
          end
        end
        OWN1: begin
          if (gnt[1] && Lock1 && !lock_hit) begin
            lock_cnt <= CNT_W'(cnt_next);
          end else begin
            owner    <= IDLE;
            lock_cnt <= '0;
          end
        end
        default: begin
          owner    <= IDLE;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      Rdata0    <= '0;
      Rdata1    <= '0;
    end else begin
      rvalid0_q <= rd0;
      rvalid1_q <= rd1;
      if (rd0) Rdata0 <= DataOut;
      if (rd1) Rdata1 <= DataOut;
    end
  end

  // A read still in flight when reset arrives must not report valid data.
  assign Rvalid0 = rvalid0_q & ~Reset;
  assign Rvalid1 = rvalid1_q & ~Reset;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed plus randomized checks against a behavioural arbiter model.
// Rev 1.0
`default_nettype none

module tb_data_mem_arbiter;

  localparam int LOCK_MAX = 4;

  logic       CLK = 1'b0;
  logic       Reset, Req0, Req1, We0, We1, Lock0, Lock1;
  logic [7:0] Addr0, Addr1, Wdata0, Wdata1;
  logic       Gnt0, Gnt1, Rvalid0, Rvalid1, ReadMem, WriteMem;
  logic [7:0] Rdata0, Rdata1, DataAddress, DataIn;
  logic [1:0] Owner;
  logic [7:0] mem [256];
  wire  [7:0] DataOut = ReadMem ? mem[DataAddress] : 8'hxx;

  int         checks = 0;
  int         errors = 0;
  int         m_owner = 0;
  int         m_cnt = 0;
  int         m_last = 1;
  bit         m_pv [2];
  logic [7:0] m_pd [2];
  logic [7:0] smem [256];
  bit         m_init = 1'b0;

  data_mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .CLK(CLK), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1), .Lock0(Lock0), .Lock1(Lock1),
    .Addr0(Addr0), .Addr1(Addr1), .Wdata0(Wdata0), .Wdata1(Wdata1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Rvalid0(Rvalid0), .Rvalid1(Rvalid1),
    .Rdata0(Rdata0), .Rdata1(Rdata1), .DataAddress(DataAddress),
    .ReadMem(ReadMem), .WriteMem(WriteMem), .DataIn(DataIn),
    .DataOut(DataOut), .Owner(Owner)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (WriteMem === 1'b1) mem[DataAddress] <= DataIn;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winning port from the arbitration rules, -1 when nobody is granted.
  function automatic int winner(input bit r0, input bit r1);
    if (m_owner == 1 && r0) return 0;
    if (m_owner == 2 && r1) return 1;
    if (r0 && r1) begin
`ifdef DATA_MEM_ARB_RR_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic drive(input bit rst,
                       input bit r0, input bit w0, input bit l0, input logic [7:0] a0, input logic [7:0] d0,
                       input bit r1, input bit w1, input bit l1, input logic [7:0] a1, input logic [7:0] d1);
    Reset = rst;
    Req0 = r0; We0 = w0; Lock0 = l0; Addr0 = a0; Wdata0 = d0;
    Req1 = r1; We1 = w1; Lock1 = l1; Addr1 = a1; Wdata1 = d1;
    #3;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
  endtask

  // Compare every output with the model, then advance one clock and update the model.
  task automatic tick();
    bit         rst = Reset;
    bit         we [2];
    bit         lk [2];
    logic [7:0] ad [2];
    logic [7:0] wd [2];
    int         w;
    int         n;
    we = '{We0, We1}; lk = '{Lock0, Lock1}; ad = '{Addr0, Addr1}; wd = '{Wdata0, Wdata1};
    w = rst ? -1 : winner(Req0, Req1);
    chk("gnt0", Gnt0, (w == 0));
    chk("gnt1", Gnt1, (w == 1));
    chk("readmem", ReadMem, (w >= 0) && !we[(w >= 0) ? w : 0]);
    chk("writemem", WriteMem, (w >= 0) && we[(w >= 0) ? w : 0]);
    chk("daddr", DataAddress, (w >= 0) ? ad[w] : 8'h00);
    chk("datain", DataIn, (w >= 0) ? wd[w] : 8'h00);
    if (m_init) begin
      chk("rvalid0", Rvalid0, m_pv[0] && !rst);
      chk("rvalid1", Rvalid1, m_pv[1] && !rst);
      chk("rdata0", Rdata0, m_pd[0]);
      chk("rdata1", Rdata1, m_pd[1]);
      chk("owner", Owner, 16'(m_owner));
    end
    @(posedge CLK);
    if (rst) begin
      m_owner = 0; m_cnt = 0; m_last = 1;
      m_pv = '{0, 0}; m_pd = '{8'h00, 8'h00};
      m_init = 1'b1;
    end else begin
      m_pv = '{0, 0};
      if (w >= 0) begin
        if (we[w]) smem[ad[w]] = wd[w];
        else begin
          m_pv[w] = 1'b1;
          m_pd[w] = smem[ad[w]];
        end
        m_last = w;
      end
      if (m_owner == 0) begin
        if (w >= 0 && lk[w]) begin m_owner = w + 1; m_cnt = 0; end
      end else begin
        n = m_owner - 1;
        if (w == n) begin
          m_cnt++;
          if (!lk[n] || m_cnt == LOCK_MAX) begin m_owner = 0; m_cnt = 0; end
        end else begin
          m_owner = 0; m_cnt = 0;
        end
      end
    end
    #1;
  endtask

  initial begin
    bit exp0;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'($urandom);
      smem[i] = mem[i];
    end

    // Reset for two cycles with both ports requesting.
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 8'h03, 8'h00, 1, 0, 0, 8'h04, 8'h00);
      chk("rst_gnt0", Gnt0, 1'b0);
      chk("rst_gnt1", Gnt1, 1'b0);
      chk("rst_readmem", ReadMem, 1'b0);
      chk("rst_writemem", WriteMem, 1'b0);
      tick();
    end
    drive(0, 1, 0, 0, 8'h03, 8'h00, 1, 0, 0, 8'h04, 8'h00);
    chk("first_grant_p0", Gnt0, 1'b1);
    tick();

    // Port 0 writes, port 1 reads the same address next cycle.
    drive(0, 1, 1, 0, 8'h10, 8'h5A, 0, 0, 0, 8'h00, 8'h00);
    chk("wr_writemem", WriteMem, 1'b1);
    chk("wr_addr", DataAddress, 8'h10);
    chk("wr_data", DataIn, 8'h5A);
    tick();
    drive(0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00);
    chk("raw_gnt1", Gnt1, 1'b1);
    tick();
    chk("raw_rvalid1", Rvalid1, 1'b1);
    chk("raw_rdata1", Rdata1, 8'h5A);
    idle(); tick();

    // Continuous contention, no locks.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 8'(i), 8'h00, 1, 0, 0, 8'h10, 8'h00);
`ifdef DATA_MEM_ARB_RR_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      chk("contend_gnt0", Gnt0, exp0);
      chk("contend_gnt1", Gnt1, !exp0);
      tick();
    end
    idle(); tick();

    // Port 1 locks for six reads while port 0 keeps requesting.
    drive(0, 0, 0, 0, 8'h20, 8'h00, 1, 0, 1, 8'h10, 8'h00);
    chk("lock_entry_gnt1", Gnt1, 1'b1);
    tick();
    chk("lock_owner1", Owner, 2'd2);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 0, 8'h20, 8'h00, 1, 0, 1, 8'(8'h11 + k), 8'h00);
      chk("locked_gnt1", Gnt1, 1'b1);
      chk("locked_gnt0", Gnt0, 1'b0);
      tick();
    end
    chk("lock_owner_idle", Owner, 2'd0);
    drive(0, 1, 0, 0, 8'h20, 8'h00, 1, 0, 1, 8'h15, 8'h00);
    chk("lock_release_gnt0", Gnt0, 1'b1);
    chk("lock_release_gnt1", Gnt1, 1'b0);
    tick();
    idle(); tick();

    // Reset right after a locked read by port 0.
    drive(0, 1, 0, 1, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("rstlock_gnt0", Gnt0, 1'b1);
    tick();
    chk("rstlock_owner0", Owner, 2'd1);
    drive(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("rstlock_rvalid_in_rst", Rvalid0, 1'b0);
    tick();
    chk("rstlock_rvalid_after", Rvalid0, 1'b0);
    chk("rstlock_owner_idle", Owner, 2'd0);
    chk("rstlock_rdata0", Rdata0, 8'h00);
    idle(); tick();
    chk("rstlock_rvalid_later", Rvalid0, 1'b0);

    // Randomized traffic on a small address window to exercise read-after-write.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0,
            8'($urandom_range(0, 7)), 8'($urandom),
            $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0,
            8'($urandom_range(0, 7)), 8'($urandom));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the single-ported 256x8 data memory. It lets the processor load/store unit (port 0) and a secondary master such as a loader or DMA (port 1) share one address pointer. Each cycle it grants at most one request and drives the memory's combinational read and sequential write controls. It registers read data back to the winner, with optional bus locking for multi-byte sequences.

## Interface
Parameters:
- LOCK_MAX, default 4: maximum consecutive locked grants before the lock is forcibly released for one arbitration.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Req0 / Req1  in  1  request valid; held until the matching Gnt is seen.
- We0 / We1  in  1  1 = write, 0 = read.
- Lock0 / Lock1  in  1  keep ownership after this grant.
- Addr0 / Addr1  in  8  byte address.
- Wdata0 / Wdata1  in  8  write data.
- Gnt0 / Gnt1  out  1  combinational; request accepted this cycle.
- Rvalid0 / Rvalid1  out  1  registered read data valid, one-cycle pulse.
- Rdata0 / Rdata1  out  8  registered read data.
- DataAddress  out  8  to memory.
- ReadMem  out  1  to memory.
- WriteMem  out  1  to memory.
- DataIn  out  8  to memory.
- DataOut  in  8  from memory; tristate when ReadMem is low.
- Owner  out  2  current lock state encoding.

## Operation
- Owner FSM has three states: IDLE=0, OWN0=1, OWN1=2.
- IDLE:
  - Winner selected by the priority rule.
  - A granted request with its Lock high moves to OWNn. Otherwise the FSM stays in IDLE.
- OWNn:
  - Port n wins whenever Reqn is high, regardless of the other port.
  - Exits to IDLE on a granted request with Lockn low.
  - Exits to IDLE on a cycle with Reqn low. The other port may be granted in that same cycle.
  - Exits to IDLE when the lock counter reaches LOCK_MAX. That grant still goes to n, and the next arbitration is unlocked.
- Lock counter:
  - Increments on each grant made in OWNn.
  - Clears on entering IDLE.
  - Width is $clog2(LOCK_MAX+1).
- Priority rule:
  - Priority applies only when both ports request in IDLE.
  - Behaviour is set by the macro (see Configuration).
  - The last-grant register updates on every grant.
- Memory drive:
  - Winner's Addr goes to DataAddress and Wdata to DataIn.
  - A winning read raises ReadMem; a winning write raises WriteMem.
  - With no grant, ReadMem=0, WriteMem=0, and DataAddress/DataIn=0.
  - At most one of ReadMem or WriteMem is high per cycle.
- Read return:
  - On a granted read, DataOut is captured at the posedge into Rdatan.
  - Rvalidn pulses high for the following cycle.
  - Rdatan holds its value until the next read by port n.
  - The non-granted port's Rdata is unchanged.
- Write: commits in memory at the posedge ending the grant cycle. No response pulse.
- Same-address read after write by either port: the read returns the new data because the grants fall in different cycles.

## Timing
- Grant latency is 0 cycles: Gnt is combinational from Req, state and the last-grant register.
- Read data latency is 1 cycle after Gnt.
- Back-to-back grants to the same port are allowed every cycle, including read-read pipelining: Rvalid is high on consecutive cycles.
- Reset:
  - While Reset is high, outputs are forced to Gnt0=Gnt1=0, ReadMem=WriteMem=0, DataAddress=DataIn=0.
  - At the first posedge with Reset high, state initialises to Rvalid0=Rvalid1=0, Rdata0=Rdata1=0, Owner=IDLE, lock counter=0.
  - The last-grant register initialises to 1, so port 0 wins the first contest.
- Reset during OWNn or with a read outstanding:
  - The lock is dropped.
  - The pending Rvalid is suppressed, with no data returned.
  - The requester re-issues after reset.

## Configuration
- DATA_MEM_ARB_RR_EN defined:
  - Round-robin in IDLE; on contention, the port not granted last wins.
- DATA_MEM_ARB_RR_EN undefined:
  - Fixed priority; port 0 always wins contention in IDLE.
  - The last-grant register still exists but does not affect selection.
- Lock behaviour is identical in both builds.

## Structure
- Shared package data_mem_arb_pkg holds:
  - typedef owner_e, the enum IDLE/OWN0/OWN1 (2 bits).
  - typedef port_idx_t (1 bit).
  - constants ADDR_W=8 and DATA_W=8.
- One natural sub-module: data_mem_arb_pick.
  - Purely combinational.
  - Inputs: Req0, Req1, Owner and the last-grant bit.
  - Outputs: the one-hot grant.
  - The RR macro is evaluated inside it.
- Top level holds the FSM, lock counter, last-grant register, memory mux and read capture registers.

## Test plan
- Reset held 2 cycles with Req0=Req1=1:
  - During reset, Gnt0=Gnt1=0 and ReadMem=WriteMem=0.
  - After release, with RR defined, the first grant is to port 0.
- Port 0 writes 0x5A to address 0x10; next cycle port 1 reads 0x10:
  - Gnt1 in the second cycle.
  - Rvalid1=1 and Rdata1=0x5A in the third cycle.
- Both ports request reads continuously with RR defined: grants alternate 0,1,0,1. Without RR, Gnt0 is held every cycle.
- Port 1 asserts Lock1 on 6 consecutive reads with LOCK_MAX=4 while port 0 requests:
  - Port 1 is granted 5 times: the unlocked entry grant plus 4 locked grants.
  - Owner then returns to IDLE and port 0 is granted in the next cycle.
- Reset asserted in the cycle after a granted read from port 0 while Owner=OWN0: Rvalid0 stays 0, Owner=IDLE, and Rdata0=0 after reset.
